// File: rtl/ofs_plat_avalon_mem_burst_split_to_rob.sv
// ofs_plat_avalon_mem_burst_split_to_rob
//
// Splits Avalon-MM source bursts (up to 2^(SRC_BURST_CNT_WIDTH-1) beats) into
// sink bursts of at most 4 beats, feeding a ROB/clock-crossing stage.
//   - Reads: sub-bursts issue combinationally from the held source request.
//     The source is stalled until the last sub-burst is accepted.
//   - Writes: flits pass 1:1. A sink SOP is marked every 4th beat. The number
//     of sub-bursts per source burst is queued so that the sub-burst write
//     responses merge into one source response.
//   - Read responses: registered pass-through with 1-cycle latency.
//
// Ports
//   clk, reset                     single clock, asynchronous active-high reset
//   src_*                          source-side Avalon-MM slave port
//   snk_*                          sink-side Avalon-MM master port
//                                  (snk_burstcount is 3 bits, max 4 beats)
//
// Configuration macro
//   OFS_PLAT_AVALON_BURST_SPLIT_CHECK_EN
//     Enables simulation protocol checks. A merged write response whose codes
//     contained X is reported with bit 1 forced high.

module ofs_plat_avalon_mem_burst_split_to_rob #(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 512,
    parameter int USER_WIDTH          = 8,
    parameter int SRC_BURST_CNT_WIDTH = 7,
    parameter int SNK_BURST_CNT_WIDTH = 3,
    parameter int WR_RSP_FIFO_DEPTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,

    output logic                           src_waitrequest,
    input  logic                           src_read,
    input  logic                           src_write,
    input  logic [ADDR_WIDTH-1:0]          src_address,
    input  logic [SRC_BURST_CNT_WIDTH-1:0] src_burstcount,
    input  logic [DATA_WIDTH-1:0]          src_writedata,
    input  logic [DATA_WIDTH/8-1:0]        src_byteenable,
    input  logic [USER_WIDTH-1:0]          src_user,
    output logic                           src_readdatavalid,
    output logic [DATA_WIDTH-1:0]          src_readdata,
    output logic [1:0]                     src_response,
    output logic                           src_writeresponsevalid,
    output logic [1:0]                     src_writeresponse,

    input  logic                           snk_waitrequest,
    output logic                           snk_read,
    output logic                           snk_write,
    output logic [ADDR_WIDTH-1:0]          snk_address,
    output logic [SNK_BURST_CNT_WIDTH-1:0] snk_burstcount,
    output logic [DATA_WIDTH-1:0]          snk_writedata,
    output logic [DATA_WIDTH/8-1:0]        snk_byteenable,
    output logic [USER_WIDTH-1:0]          snk_user,
    input  logic                           snk_readdatavalid,
    input  logic [DATA_WIDTH-1:0]          snk_readdata,
    input  logic [1:0]                     snk_response,
    input  logic                           snk_writeresponsevalid,
    input  logic [1:0]                     snk_writeresponse
);

    localparam int CW = SRC_BURST_CNT_WIDTH;
    localparam int PW = $clog2(WR_RSP_FIFO_DEPTH);

    if (SNK_BURST_CNT_WIDTH != 3) begin : g_bad_snk_width
        $error("SNK_BURST_CNT_WIDTH must be 3");
    end

    function automatic logic [2:0] min4(input logic [CW-1:0] n);
        return (n >= CW'(4)) ? 3'd4 : n[2:0];
    endfunction

    // ------------------------------------------------------------------
    // Read splitting: rd_off_q is the beat offset of the current sub-burst
    // ------------------------------------------------------------------
    logic [CW-1:0] rd_off_q, rd_off_d;
    logic [CW-1:0] rd_rem;
    logic          rd_last;
    logic          rd_acc;

    assign rd_rem  = src_burstcount - rd_off_q;
    assign rd_last = (rd_rem <= CW'(4));
    assign rd_acc  = src_read && !snk_waitrequest;

    always_comb begin
        rd_off_d = rd_off_q;
        if (rd_acc) rd_off_d = rd_last ? '0 : rd_off_q + CW'(4);
    end

    // ------------------------------------------------------------------
    // Write splitting: wr_beat_q counts beats sent in the source burst.
    // Address/burstcount are captured at each sink SOP so that the
    // remaining flits of the sub-burst carry the same values.
    // ------------------------------------------------------------------
    logic [CW-1:0]         wr_beat_q, wr_beat_d, wr_beat_inc;
    logic [CW-1:0]         wr_len_q, wr_len;
    logic [ADDR_WIDTH-1:0] wr_base_q, wr_base;
    logic [ADDR_WIDTH-1:0] wr_hold_addr_q, wr_sop_addr;
    logic [2:0]            wr_hold_cnt_q, wr_sop_cnt;
    logic                  wr_src_sop, wr_snk_sop, wr_stall, wr_acc;

    // Response-count FIFO
    logic [CW-1:0] fifo_mem [WR_RSP_FIFO_DEPTH];
    logic [PW-1:0] fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [PW:0]   fifo_cnt_q;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign fifo_full  = (fifo_cnt_q == (PW+1)'(WR_RSP_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);

    assign wr_src_sop  = (wr_beat_q == '0);
    assign wr_snk_sop  = (wr_beat_q[1:0] == 2'b00);
    assign wr_len      = wr_src_sop ? src_burstcount : wr_len_q;
    assign wr_base     = wr_src_sop ? src_address : wr_base_q;
    assign wr_sop_addr = wr_base + ADDR_WIDTH'(wr_beat_q);
    assign wr_sop_cnt  = min4(wr_len - wr_beat_q);
    // A new source burst may not start until its response count has a slot
    assign wr_stall    = wr_src_sop && fifo_full;
    assign wr_acc      = src_write && !snk_waitrequest && !wr_stall;
    assign wr_beat_inc = wr_beat_q + 1'b1;
    assign wr_beat_d   = wr_acc ? ((wr_beat_inc == wr_len) ? '0 : wr_beat_inc) : wr_beat_q;
    assign fifo_push   = wr_acc && wr_src_sop;

    // ------------------------------------------------------------------
    // Sink request / source stall (combinational, forced idle in reset)
    // ------------------------------------------------------------------
    always_comb begin
        src_waitrequest = 1'b0;
        snk_read        = 1'b0;
        snk_write       = 1'b0;
        snk_address     = '0;
        snk_burstcount  = '0;
        snk_writedata   = '0;
        snk_byteenable  = '0;
        snk_user        = '0;
        if (!reset) begin
            src_waitrequest = snk_waitrequest;
            snk_writedata   = src_writedata;
            snk_byteenable  = src_byteenable;
            snk_user        = src_user;
            if (src_read) begin
                snk_read        = 1'b1;
                snk_address     = src_address + ADDR_WIDTH'(rd_off_q);
                snk_burstcount  = min4(rd_rem);
                src_waitrequest = snk_waitrequest || !rd_last;
            end else if (src_write) begin
                snk_write       = !wr_stall;
                snk_address     = wr_snk_sop ? wr_sop_addr : wr_hold_addr_q;
                snk_burstcount  = wr_snk_sop ? wr_sop_cnt : wr_hold_cnt_q;
                src_waitrequest = snk_waitrequest || wr_stall;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-response merge
    // ------------------------------------------------------------------
    logic [CW-1:0] rsp_seen_q, rsp_seen_inc;
    logic [1:0]    rsp_err_q, rsp_merged;
    logic          wrsp_vld_q;
    logic [1:0]    wrsp_code_q;

    assign rsp_seen_inc = rsp_seen_q + 1'b1;
    // Final response of the head burst: all earlier ones already counted
    assign fifo_pop     = snk_writeresponsevalid && !fifo_empty &&
                          (rsp_seen_inc == fifo_mem[fifo_rd_ptr_q]);

    always_comb begin
        rsp_merged = rsp_err_q | snk_writeresponse;
`ifdef OFS_PLAT_AVALON_BURST_SPLIT_CHECK_EN
        if ($isunknown(rsp_merged)) rsp_merged[1] = 1'b1;
`endif
    end

    // Read-response pass-through
    logic                  rdv_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr_q] <= (src_burstcount + CW'(3)) >> 2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_off_q       <= '0;
            wr_beat_q      <= '0;
            wr_len_q       <= '0;
            wr_base_q      <= '0;
            wr_hold_addr_q <= '0;
            wr_hold_cnt_q  <= '0;
            fifo_wr_ptr_q  <= '0;
            fifo_rd_ptr_q  <= '0;
            fifo_cnt_q     <= '0;
            rsp_seen_q     <= '0;
            rsp_err_q      <= '0;
            wrsp_vld_q     <= 1'b0;
            wrsp_code_q    <= '0;
            rdv_q          <= 1'b0;
            rdata_q        <= '0;
            rresp_q        <= '0;
        end else begin
            rd_off_q  <= rd_off_d;
            wr_beat_q <= wr_beat_d;
            if (wr_acc && wr_src_sop) begin
                wr_len_q  <= src_burstcount;
                wr_base_q <= src_address;
            end
            if (wr_acc && wr_snk_sop) begin
                wr_hold_addr_q <= wr_sop_addr;
                wr_hold_cnt_q  <= wr_sop_cnt;
            end

            if (fifo_push) fifo_wr_ptr_q <= fifo_wr_ptr_q + 1'b1;
            if (fifo_pop)  fifo_rd_ptr_q <= fifo_rd_ptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            wrsp_vld_q <= 1'b0;
            if (fifo_pop) begin
                wrsp_vld_q  <= 1'b1;
                wrsp_code_q <= rsp_merged;
                rsp_err_q   <= '0;
                rsp_seen_q  <= '0;
            end else if (snk_writeresponsevalid) begin
                rsp_err_q  <= rsp_merged;
                rsp_seen_q <= rsp_seen_inc;
            end

            rdv_q   <= snk_readdatavalid;
            rdata_q <= snk_readdata;
            rresp_q <= snk_response;
        end
    end

    assign src_readdatavalid      = rdv_q;
    assign src_readdata           = rdata_q;
    assign src_response           = rresp_q;
    assign src_writeresponsevalid = wrsp_vld_q;
    assign src_writeresponse      = wrsp_code_q;

`ifdef OFS_PLAT_AVALON_BURST_SPLIT_CHECK_EN
    always @(posedge clk) begin
        if (!reset) begin
            assert (!((src_read || (src_write && wr_src_sop)) && src_burstcount == '0))
                else $error("burstcount 0 on source request");
            assert (!(src_read && src_write))
                else $error("read and write asserted together");
            assert (!(snk_writeresponsevalid && fifo_empty))
                else $error("write response with no outstanding burst");
            assert (!(fifo_push && fifo_full))
                else $error("push to full response-count FIFO");
        end
    end
`endif

endmodule
